sha1_multiround_core: RTL and testbench
=======================================

# sha1_multiround_core

Parametrised SHA-1 compression engine that processes one pre-padded 512-bit block per transaction and chains intermediate hash state across blocks of a multi-block message. It unrolls ROUNDS_PER_CYCLE rounds per clock, keeps a rolling 16-word message schedule, and exposes a valid/ready block input and a pulsed digest output. It sits between the message padder/block buffer and the digest readout logic of the Nexys A7 SHA-1 design.

## Interface
- ROUNDS_PER_CYCLE, default 1: rounds per clock; legal values 1, 2, 4, 5, 8, 10, 16, 20; others are an elaboration error.
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- block_valid  input  1  block and block_first are valid.
- block_ready  output  1  core can accept a block; high only in IDLE.
- block_first  input  1  1 = first block of a new message, so chaining state starts from the IV; 0 = continue from the current digest.
- block  input  512  padded block; W0 = block[511:480], W15 = block[31:0], big-endian words.
- digest  output  160  chaining state; H0 = digest[159:128], H4 = digest[31:0].
- digest_valid  output  1  one-cycle pulse when digest is updated.
- busy  output  1  high when not IDLE.
- block_count  output  32  blocks completed since the last block_first; present only with SHA1_BLOCK_CNT_EN.

## Operation
- N = 80 / ROUNDS_PER_CYCLE compression cycles per block.
- States are IDLE, ROUNDS and FINAL.
- **IDLE:** block_ready is high. On block_valid && block_ready:
  - Capture the 16 W words into the schedule window.
  - Load a..e from the IV if block_first, else from digest.
  - If block_first, also load the H registers from the IV.
  - Clear the round counter and go to ROUNDS.
- **ROUNDS:** each cycle applies ROUNDS_PER_CYCLE consecutive rounds t..t+R-1.
  - Per round: T = rotl5(a) + f_t(b,c,d) + e + K_t + W_t; e=d; d=c; c=rotl30(b); b=a; a=T.
  - f_t: Ch for t 0–19, Parity for t 20–39 and 60–79, Maj for t 40–59.
  - K_t: 5a827999, 6ed9eba1, 8f1bbcdc, ca62c1d6 per 20-round group.
  - Rotations are true rotates, not shifts.
  - All additions are mod 2^32.
  - Schedule: for t ≥ 16, W_t = rotl1(W_{t-3} ^ W_{t-8} ^ W_{t-14} ^ W_{t-16}), computed in the rolling 16-word window. No 80-word memory.
  - A round group never straddles a K/f boundary in a way that changes the result: f and K are selected per individual round.
  - After the cycle covering round 79, go to FINAL.
- **FINAL:** H_i += {a,b,c,d,e}_i mod 2^32, pulse digest_valid, return to IDLE.
- block_valid while block_ready is low is ignored. The sender must hold block_valid until accepted.
- digest holds its value between updates.

## Timing
- Reset values:
  - state IDLE; block_ready 1; busy 0; digest_valid 0; block_count 0.
  - digest = 67452301 efcdab89 98badcfe 10325476 c3d2e1f0.
  - a..e and the schedule are 0.
- Acceptance edge is E0. Edges E1..EN perform rounds. Edge E(N+1) updates digest and sets digest_valid.
  - digest_valid is high for exactly the cycle after E(N+1).
  - block_ready is high again in that same cycle.
- Latency from acceptance to the digest_valid cycle is N+2 clocks: 82 for R=1, 22 for R=4.
- Throughput is one block per N+2 clocks. A new block may be accepted in the digest_valid cycle.
- block_first with a chained digest pending: the IV always wins for that block.
- Reset mid-operation aborts the current block and returns every output to its reset value on the next edge. No partial digest is visible.

## Configuration
- SHA1_BLOCK_CNT_EN defined:
  - block_count port exists.
  - Set to 1 at FINAL of a block_first block; otherwise incremented at FINAL.
  - Saturates at FFFFFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package sha1_pkg contains:
  - The IV constants and the four K constants.
  - The state enum (IDLE, ROUNDS, FINAL).
  - An f-select function of round index.
  - rotl helpers.
- Sub-module sha1_round: combinational single round (inputs a..e, W, round index; outputs a..e). It is instantiated ROUNDS_PER_CYCLE times in a generate chain.
- Schedule expansion for R words per cycle lives in the core.

## Test plan
- Reset, then "abc" padded block with block_first=1, R=1 → digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d. digest_valid pulse is exactly 82 cycles after acceptance.
- Empty-string padded block, R=4 → da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709 after 22 cycles.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with first=1, block 2 with first=0 → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - With SHA1_BLOCK_CNT_EN, block_count=2.
- Back-to-back: "abc" then "abc" with first=1, the second presented in the digest_valid cycle → accepted that cycle, with the same digest both times.
- Assert rst during round 40 → next edge: digest=IV, busy=0, block_ready=1, no digest_valid pulse. A following "abc" hashes correctly.
- block_valid held while busy → no second acceptance. The block is taken only once block_ready rises.

Source files
------------

// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
// sha1_pkg
// Shared SHA-1 constants, FSM state type, per-round f/K selection, rotates.
// Revision: 1.0
// ============================================================================
package sha1_pkg;

    localparam logic [159:0] c_IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    localparam logic [31:0] c_K0 = 32'h5a827999;
    localparam logic [31:0] c_K1 = 32'h6ed9eba1;
    localparam logic [31:0] c_K2 = 32'h8f1bbcdc;
    localparam logic [31:0] c_K3 = 32'hca62c1d6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        FINAL  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        F_CH     = 2'd0,
        F_PARITY = 2'd1,
        F_MAJ    = 2'd2
    } fsel_t;

    function automatic fsel_t f_select(input logic [6:0] t);
        if (t < 7'd20)      return F_CH;
        else if (t < 7'd40) return F_PARITY;
        else if (t < 7'd60) return F_MAJ;
        else                return F_PARITY;
    endfunction

    function automatic logic [31:0] k_select(input logic [6:0] t);
        if (t < 7'd20)      return c_K0;
        else if (t < 7'd40) return c_K1;
        else if (t < 7'd60) return c_K2;
        else                return c_K3;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_round.sv
`default_nettype none
// ============================================================================
// sha1_round
// One combinational SHA-1 round; f and K are chosen from the round index.
// Revision: 1.0
// ============================================================================
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_e,
    input  logic [31:0] i_w,
    input  logic [6:0]  i_t,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d,
    output logic [31:0] o_e
);

    logic [31:0] w_f;

    always_comb begin
        w_f = i_b ^ i_c ^ i_d;
        case (f_select(i_t))
            F_CH:    w_f = (i_b & i_c) | (~i_b & i_d);
            F_MAJ:   w_f = (i_b & i_c) | (i_b & i_d) | (i_c & i_d);
            default: w_f = i_b ^ i_c ^ i_d;
        endcase
    end

    assign o_a = rotl(i_a, 5) + w_f + i_e + k_select(i_t) + i_w;
    assign o_b = i_a;
    assign o_c = rotl(i_b, 30);
    assign o_d = i_c;
    assign o_e = i_d;

endmodule
`default_nettype wire

// File: rtl/sha1_multiround_core.sv
`default_nettype none
// ============================================================================
// sha1_multiround_core
// SHA-1 compression engine, ROUNDS_PER_CYCLE unrolled rounds per clock, with
// block chaining. Optional block counter enabled by macro SHA1_BLOCK_CNT_EN.
// Revision: 1.0
// ============================================================================
module sha1_multiround_core
    import sha1_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic         block_first,
    input  logic [511:0] block,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         busy
`ifdef SHA1_BLOCK_CNT_EN
    ,
    output logic [31:0]  block_count
`endif
);

    localparam int       c_R      = ROUNDS_PER_CYCLE;
    localparam logic [6:0] c_LAST_T = 7'(80 - c_R);

    generate
        if (!(c_R == 1 || c_R == 2 || c_R == 4 || c_R == 5 || c_R == 8 ||
              c_R == 10 || c_R == 16 || c_R == 20)) begin : g_bad_rpc
            $error("sha1_multiround_core: illegal ROUNDS_PER_CYCLE");
        end
    endgenerate

    state_t      r_state;
    logic [6:0]  r_t;
    logic [31:0] r_a, r_b, r_c, r_d, r_e;
    logic [31:0] r_h   [0:4];
    logic [31:0] r_win [0:15];
    logic        r_dv;

    // Window holds W_t..W_t+15; extend by R words so a full cycle's worth
    // of schedule is available even when R exceeds the window depth.
    logic [31:0] w_ext [0:c_R+15];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = r_win[i];
        end
        for (int i = 16; i < c_R + 16; i++) begin
            w_ext[i] = rotl(w_ext[i-3] ^ w_ext[i-8] ^ w_ext[i-14] ^ w_ext[i-16], 1);
        end
    end

    logic [31:0] w_sa [0:c_R];
    logic [31:0] w_sb [0:c_R];
    logic [31:0] w_sc [0:c_R];
    logic [31:0] w_sd [0:c_R];
    logic [31:0] w_se [0:c_R];

    assign w_sa[0] = r_a;
    assign w_sb[0] = r_b;
    assign w_sc[0] = r_c;
    assign w_sd[0] = r_d;
    assign w_se[0] = r_e;

    generate
        for (genvar j = 0; j < c_R; j++) begin : g_round
            sha1_round u_round (
                .i_a (w_sa[j]),
                .i_b (w_sb[j]),
                .i_c (w_sc[j]),
                .i_d (w_sd[j]),
                .i_e (w_se[j]),
                .i_w (w_ext[j]),
                .i_t (r_t + 7'(j)),
                .o_a (w_sa[j+1]),
                .o_b (w_sb[j+1]),
                .o_c (w_sc[j+1]),
                .o_d (w_sd[j+1]),
                .o_e (w_se[j+1])
            );
        end
    endgenerate

`ifdef SHA1_BLOCK_CNT_EN
    logic        r_first;
    logic [31:0] r_cnt;
    assign block_count = r_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            r_dv    <= 1'b0;
            for (int i = 0; i < 5; i++)  r_h[i]   <= c_IV[159-32*i -: 32];
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
`ifdef SHA1_BLOCK_CNT_EN
            r_first <= 1'b0;
            r_cnt   <= '0;
`endif
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (block_valid) begin
                        for (int i = 0; i < 16; i++) r_win[i] <= block[511-32*i -: 32];
                        if (block_first) begin
                            r_a <= c_IV[159:128];
                            r_b <= c_IV[127:96];
                            r_c <= c_IV[95:64];
                            r_d <= c_IV[63:32];
                            r_e <= c_IV[31:0];
                            for (int i = 0; i < 5; i++) r_h[i] <= c_IV[159-32*i -: 32];
                        end else begin
                            r_a <= r_h[0];
                            r_b <= r_h[1];
                            r_c <= r_h[2];
                            r_d <= r_h[3];
                            r_e <= r_h[4];
                        end
`ifdef SHA1_BLOCK_CNT_EN
                        r_first <= block_first;
`endif
                        r_t     <= '0;
                        r_state <= ROUNDS;
                    end
                end
                ROUNDS: begin
                    r_a <= w_sa[c_R];
                    r_b <= w_sb[c_R];
                    r_c <= w_sc[c_R];
                    r_d <= w_sd[c_R];
                    r_e <= w_se[c_R];
                    for (int i = 0; i < 16; i++) r_win[i] <= w_ext[i+c_R];
                    r_t <= r_t + 7'(c_R);
                    if (r_t == c_LAST_T) r_state <= FINAL;
                end
                FINAL: begin
                    r_h[0]  <= r_h[0] + r_a;
                    r_h[1]  <= r_h[1] + r_b;
                    r_h[2]  <= r_h[2] + r_c;
                    r_h[3]  <= r_h[3] + r_d;
                    r_h[4]  <= r_h[4] + r_e;
                    r_dv    <= 1'b1;
                    r_state <= IDLE;
`ifdef SHA1_BLOCK_CNT_EN
                    if (r_first)                r_cnt <= 32'd1;
                    else if (r_cnt != '1)       r_cnt <= r_cnt + 32'd1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign digest       = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4]};
    assign digest_valid = r_dv;
    assign block_ready  = (r_state == IDLE);
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sha1_multiround_core.sv
`default_nettype none
// ============================================================================
// tb_sha1_multiround_core
// Two instances (1 and 4 rounds/cycle) checked each cycle against a
// behavioural SHA-1 model; known digests pin the model.
// Revision: 1.0
// ============================================================================
module tb_sha1_multiround_core;

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         bv  [2];
    logic         bf  [2];
    logic [511:0] blk [2];
    logic         rdy [2];
    logic         dvo [2];
    logic         bsy [2];
    logic [159:0] dg  [2];
`ifdef SHA1_BLOCK_CNT_EN
    logic [31:0]  bc  [2];
`endif

    sha1_multiround_core #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .block_valid  (bv[0]),
        .block_ready  (rdy[0]),
        .block_first  (bf[0]),
        .block        (blk[0]),
        .digest       (dg[0]),
        .digest_valid (dvo[0]),
        .busy         (bsy[0])
`ifdef SHA1_BLOCK_CNT_EN
        ,
        .block_count  (bc[0])
`endif
    );

    sha1_multiround_core #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .block_valid  (bv[1]),
        .block_ready  (rdy[1]),
        .block_first  (bf[1]),
        .block        (blk[1]),
        .digest       (dg[1]),
        .digest_valid (dvo[1]),
        .busy         (bsy[1])
`ifdef SHA1_BLOCK_CNT_EN
        ,
        .block_count  (bc[1])
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int           m_left [2];
    int           m_acc  [2];
    logic [159:0] m_dig  [2];
    logic [159:0] m_pend [2];
    logic         m_dv   [2];
    logic         m_first[2];
    logic [31:0]  m_cnt  [2];

    logic [511:0] pblk [4];

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] bk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = bk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            t = rol(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rol(b, 30); b = a; a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic int pad_msg(input string s);
        logic [7:0]  by [0:255];
        logic [63:0] bl;
        int L, nb;
        L  = s.len();
        nb = (L + 8) / 64 + 1;
        for (int i = 0; i < 256; i++) by[i] = 8'h00;
        for (int i = 0; i < L; i++) by[i] = s[i];
        by[L] = 8'h80;
        bl = 64'(L) * 64'd8;
        for (int i = 0; i < 8; i++) by[nb*64-1-i] = bl[8*i +: 8];
        for (int k = 0; k < nb; k++)
            for (int j = 0; j < 64; j++) pblk[k][511-8*j -: 8] = by[64*k+j];
        return nb;
    endfunction

    function automatic int nrounds(input int u);
        return (u == 0) ? 80 : 20;
    endfunction

    task automatic chk(input string nm, input int u, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s u%0d got %h want %h", nm, u, act, exp);
        end
    endtask

    // Reference model: transaction-level timing (accept, N+1 edges later the
    // digest appears) with the SHA-1 result computed at acceptance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                m_left[u] = 0; m_dig[u] = IV; m_dv[u] = 1'b0; m_cnt[u] = '0;
            end
        end else begin
            cyc++;
            for (int u = 0; u < 2; u++) begin
                m_dv[u] = 1'b0;
                if (m_left[u] == 0) begin
                    if (bv[u]) begin
                        m_first[u] = bf[u];
                        if (bf[u]) m_dig[u] = IV;
                        m_pend[u] = sha1_compress(m_dig[u], blk[u]);
                        m_left[u] = nrounds(u) + 1;
                        m_acc[u]  = cyc;
                    end
                end else begin
                    m_left[u]--;
                    if (m_left[u] == 0) begin
                        m_dig[u] = m_pend[u];
                        m_dv[u]  = 1'b1;
                        if (m_first[u])              m_cnt[u] = 32'd1;
                        else if (m_cnt[u] != '1)     m_cnt[u] = m_cnt[u] + 32'd1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                chk("ready", u, {159'b0, rdy[u]}, {159'b0, m_left[u] == 0});
                chk("busy", u, {159'b0, bsy[u]}, {159'b0, m_left[u] != 0});
                chk("digest_valid", u, {159'b0, dvo[u]}, {159'b0, m_dv[u]});
                chk("digest", u, dg[u], m_dig[u]);
`ifdef SHA1_BLOCK_CNT_EN
                chk("block_count", u, {128'b0, bc[u]}, {128'b0, m_cnt[u]});
`endif
            end
        end
    end

    task automatic send(input int u, input logic [511:0] b, input logic f, input bit hold);
        int k;
        bv[u] = 1'b1; blk[u] = b; bf[u] = f;
        k = 0;
        while (!rdy[u] && k < 300) begin @(negedge clk); k++; end
        if (!rdy[u]) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout u%0d ready %b want 1", u, rdy[u]);
        end
        @(negedge clk);
        if (!hold) bv[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int k;
        k = 0;
        while (!dvo[u] && k < 300) begin @(negedge clk); k++; end
        n_checks++;
        if (!dvo[u]) begin
            n_errors++;
            $display("FAIL done_timeout u%0d digest_valid %b want 1", u, dvo[u]);
        end
    endtask

    task automatic rand_run(input int u);
        logic [511:0] b;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom;
            send(u, b, (i == 0) || ($urandom_range(0, 2) == 0), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_done(u);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [511:0] b_abc, b_empty, b_one, b_two;
    int n;

    initial begin
        for (int u = 0; u < 2; u++) begin bv[u] = 1'b0; bf[u] = 1'b0; blk[u] = '0; end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_digest", u, dg[u], IV);
            chk("rst_ready", u, {159'b0, rdy[u]}, 160'd1);
            chk("rst_busy", u, {159'b0, bsy[u]}, 160'd0);
            chk("rst_dv", u, {159'b0, dvo[u]}, 160'd0);
`ifdef SHA1_BLOCK_CNT_EN
            chk("rst_count", u, {128'b0, bc[u]}, 160'd0);
`endif
        end
        rst = 1'b0;

        n = pad_msg("abc");  b_abc   = pblk[0];
        n = pad_msg("");     b_empty = pblk[0];
        n = pad_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        b_one = pblk[0]; b_two = pblk[1];
        chk("model_abc", 0, sha1_compress(IV, b_abc), D_ABC);
        chk("model_empty", 0, sha1_compress(IV, b_empty), D_EMPTY);
        chk("model_two", 0, sha1_compress(sha1_compress(IV, b_one), b_two), D_TWO);

        @(negedge clk);
        send(0, b_abc, 1'b1, 1'b0);
        wait_done(0);
        chk("abc_digest", 0, dg[0], D_ABC);
        chk("abc_latency", 0, 160'(cyc - m_acc[0] + 1), 160'd82);

        send(1, b_empty, 1'b1, 1'b0);
        wait_done(1);
        chk("empty_digest", 1, dg[1], D_EMPTY);
        chk("empty_latency", 1, 160'(cyc - m_acc[1] + 1), 160'd22);

        for (int u = 0; u < 2; u++) begin
            send(u, b_one, 1'b1, 1'b0);
            wait_done(u);
            send(u, b_two, 1'b0, 1'b0);
            wait_done(u);
            chk("two_digest", u, dg[u], D_TWO);
`ifdef SHA1_BLOCK_CNT_EN
            chk("two_count", u, {128'b0, bc[u]}, 160'd2);
`endif
        end

        // block_valid stays high throughout; second copy goes in the pulse cycle
        send(0, b_abc, 1'b1, 1'b1);
        wait_done(0);
        chk("b2b_first", 0, dg[0], D_ABC);
        chk("b2b_lat1", 0, 160'(cyc - m_acc[0] + 1), 160'd82);
        chk("b2b_ready", 0, {159'b0, rdy[0]}, 160'd1);
        @(negedge clk);
        bv[0] = 1'b0;
        chk("b2b_accepted", 0, {159'b0, bsy[0]}, 160'd1);
        wait_done(0);
        chk("b2b_second", 0, dg[0], D_ABC);

        // chained block so that a partial update would differ from the IV
        send(0, b_abc, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_digest", 0, dg[0], IV);
        chk("midrst_busy", 0, {159'b0, bsy[0]}, 160'd0);
        chk("midrst_ready", 0, {159'b0, rdy[0]}, 160'd1);
        chk("midrst_dv", 0, {159'b0, dvo[0]}, 160'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, b_abc, 1'b1, 1'b0);
        wait_done(0);
        chk("post_rst_abc", 0, dg[0], D_ABC);

        fork
            rand_run(0);
            rand_run(1);
        join

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
